// File: rtl/harvard_pkg.sv
// Constants shared by the Harvard core and the fetch-entry type handed to the control unit.
package harvard_pkg;

    localparam int HV_DATA_W        = 8;
    localparam int HV_ADDR_W        = 8;
    localparam int HV_FETCH_DEPTH   = 4;
    localparam int HV_FETCH_MEM_LAT = 1;
    localparam logic [HV_ADDR_W-1:0] HV_RESET_PC = '0;

    typedef struct packed {
        logic [HV_ADDR_W-1:0] pc;
        logic [HV_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, instr} with flush, occupancy count and a registered head.
module fetch_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_push_data,
    input  logic [ADDR_W-1:0]      i_push_pc,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_head_data,
    output logic [ADDR_W-1:0]      o_head_pc,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_head_data;
    logic [ADDR_W-1:0] r_head_pc;

    logic             w_push;
    logic             w_pop;
    logic             w_load_push;
    logic [PTR_W-1:0] w_rd_ptr_inc;

    assign w_pop        = i_pop && (r_count != CNT_ZERO);
    assign w_push       = i_push && ((r_count != CNT_FULL) || w_pop);
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
    // The incoming entry becomes the head directly when nothing older will be left behind.
    assign w_load_push  = w_push && ((r_count == CNT_ZERO) || (w_pop && (r_count == CNT_ONE)));

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem_data[r_wr_ptr] <= i_push_data;
            r_mem_pc[r_wr_ptr]   <= i_push_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head_data <= '0;
            r_head_pc   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop && (r_count > CNT_ONE)) begin
                r_head_data <= r_mem_data[w_rd_ptr_inc];
                r_head_pc   <= r_mem_pc[w_rd_ptr_inc];
            end else if (w_load_push) begin
                r_head_data <= i_push_data;
                r_head_pc   <= i_push_pc;
            end
        end
    end

    assign o_valid     = (r_count != CNT_ZERO);
    assign o_head_data = r_head_data;
    assign o_head_pc   = r_head_pc;
    assign o_count     = r_count;

endmodule

// File: rtl/prog_fetch_unit.sv
// Sequential instruction prefetch from Harvard program memory with redirect flush.
// Define FETCH_STATS_EN to add the squash_cnt output counting entries discarded by redirects.
module prog_fetch_unit
    import harvard_pkg::*;
#(
    parameter int                DATA_W   = HV_DATA_W,
    parameter int                ADDR_W   = HV_ADDR_W,
    parameter int                DEPTH    = HV_FETCH_DEPTH,
    parameter int                MEM_LAT  = HV_FETCH_MEM_LAT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(HV_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   prog_rd_en,
    output logic [ADDR_W-1:0]      addr_program,
    input  logic [DATA_W-1:0]      data_program,
    output logic                   ins_valid,
    output logic [DATA_W-1:0]      ins_data,
    output logic [ADDR_W-1:0]      ins_pc,
    input  logic                   ins_ready,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef FETCH_STATS_EN
    ,
    output logic [7:0]             squash_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 2;

    logic [ADDR_W-1:0]  r_fpc;
    logic [MEM_LAT-1:0] r_stage_vld;
    logic [ADDR_W-1:0]  r_stage_pc [MEM_LAT];

    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [SUM_W-1:0]   w_inflight;
    logic [SUM_W-1:0]   w_occupancy;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            w_inflight = w_inflight + SUM_W'(r_stage_vld[i]);
        end
    end

    // Credits count buffered plus outstanding reads; a same-cycle pop is not credited.
    assign w_occupancy  = SUM_W'(w_fifo_count) + w_inflight;
    assign w_issue      = !rst && !redirect_valid && (w_occupancy < SUM_W'(DEPTH));
    assign prog_rd_en   = w_issue;
    assign addr_program = w_issue ? r_fpc : '0;

    assign w_push = r_stage_vld[MEM_LAT-1] && !redirect_valid;
    assign w_pop  = ins_valid && ins_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fpc <= redirect_pc;
        end else if (w_issue) begin
            r_fpc <= r_fpc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_stage_vld <= '0;
        end else begin
            r_stage_vld[0] <= w_issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_stage_vld[i] <= r_stage_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_stage_pc[0] <= r_fpc;
        for (int i = 1; i < MEM_LAT; i++) begin
            r_stage_pc[i] <= r_stage_pc[i-1];
        end
    end

    fetch_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (data_program),
        .i_push_pc   (r_stage_pc[MEM_LAT-1]),
        .i_pop       (w_pop),
        .o_valid     (ins_valid),
        .o_head_data (ins_data),
        .o_head_pc   (ins_pc),
        .o_count     (w_fifo_count)
    );

    assign fifo_count = w_fifo_count;

`ifdef FETCH_STATS_EN
    logic [7:0] r_squash_cnt;
    logic [8:0] w_squash_sum;

    // Occupancy already includes the stage returning this cycle.
    assign w_squash_sum = {1'b0, r_squash_cnt} + 9'(w_occupancy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_squash_cnt <= '0;
        end else if (redirect_valid) begin
            r_squash_cnt <= w_squash_sum[8] ? 8'hFF : w_squash_sum[7:0];
        end
    end

    assign squash_cnt = r_squash_cnt;
`endif

endmodule
